axis_rr_arb2: RTL and testbench

AXIS_RR_ARB2 -- requirements
Module: axis_rr_arb2

---
 rtl/axis_arb_pkg.sv | 20 ++
 rtl/axis_out_stage.sv | 37 +++
 rtl/axis_rr_arb2.sv | 120 ++++++++++++
 tb/tb_axis_rr_arb2.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types for the two-port AXI-Stream round-robin arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axis_arb_pkg;

  // Number of arbitrated input ports
  localparam int NUM_PORTS = 2;

  // Arbiter FSM: IDLE spends one cycle choosing a port, BUSY streams the packet
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Turns a port index into the one-hot grant vector
  function automatic logic [NUM_PORTS-1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/axis_out_stage.sv
// One-deep registered AXI-Stream output slice (data, valid, last).
// Latency: an accepted beat appears on out_* one clock later.
// Backpressure: in_ready = ~out_valid | out_ready, so a held beat stalls input while a draining beat allows a same-cycle refill.
module axis_out_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  // Slot can take a new beat when empty or when its current beat leaves now
  assign in_ready = ~out_valid | out_ready;

  // Load on input handshake, otherwise drop valid once the downstream takes the beat
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_rr_arb2.sv
// Two-port packet-locked round-robin AXI-Stream arbiter with per-port packet counters.
// Latency: one arbitration cycle before a packet's first beat, then one cycle through the output register.
// Backpressure: only the granted port sees ready, equal to the output slot's ready; the other port is held off.
module axis_rr_arb2
  import axis_arb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s0_tdata_in,
  input  logic              s0_tvalid_in,
  input  logic              s0_last_in,
  output logic              s0_tready_out,
  input  logic [DATA_W-1:0] s1_tdata_in,
  input  logic              s1_tvalid_in,
  input  logic              s1_last_in,
  output logic              s1_tready_out,
  output logic [DATA_W-1:0] m_tdata_out,
  output logic              m_tvalid_out,
  output logic              m_last_out,
  input  logic              m_tready_in,
  output logic [1:0]        grant_out,
  output logic [CNT_W-1:0]  pkt_cnt0_out,
  output logic [CNT_W-1:0]  pkt_cnt1_out
);

  arb_state_t        state;
  logic              grant_idx;   // port owning the current packet
  logic              rr_ptr;      // port favoured on the next tie
  logic              pick_idx;
  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic              os_in_valid;
  logic              os_in_ready;
  logic              xfer;

  // Tie goes to the pointer; a lone requester wins outright
  always_comb begin
    pick_idx = 1'b0;
    if (s0_tvalid_in && s1_tvalid_in) begin
      pick_idx = rr_ptr;
    end else if (s1_tvalid_in) begin
      pick_idx = 1'b1;
    end
  end

  // Route the granted port's beat toward the output slot
  always_comb begin
    sel_valid = s0_tvalid_in;
    sel_last  = s0_last_in;
    sel_data  = s0_tdata_in;
    if (grant_idx) begin
      sel_valid = s1_tvalid_in;
      sel_last  = s1_last_in;
      sel_data  = s1_tdata_in;
    end
  end

  assign os_in_valid   = (state == BUSY) && sel_valid;
  assign xfer          = os_in_valid && os_in_ready;
  assign s0_tready_out = (state == BUSY) && !grant_idx && os_in_ready;
  assign s1_tready_out = (state == BUSY) &&  grant_idx && os_in_ready;

  // Arbitration FSM: choose a port in IDLE, hold it until its last beat moves
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant_idx    <= 1'b0;
      rr_ptr       <= 1'b0;
      grant_out    <= 2'b00;
      pkt_cnt0_out <= '0;
      pkt_cnt1_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s0_tvalid_in || s1_tvalid_in) begin
            state     <= BUSY;
            grant_idx <= pick_idx;
            grant_out <= idx_to_onehot(pick_idx);
          end
        end
        BUSY: begin
          if (xfer && sel_last) begin
            state     <= IDLE;
            rr_ptr    <= ~grant_idx;
            grant_out <= 2'b00;
            if (grant_idx) begin
              pkt_cnt1_out <= pkt_cnt1_out + CNT_W'(1);
            end else begin
              pkt_cnt0_out <= pkt_cnt0_out + CNT_W'(1);
            end
          end
        end
        default: begin
          state     <= IDLE;
          grant_out <= 2'b00;
        end
      endcase
    end
  end

  axis_out_stage #(
    .DATA_W(DATA_W)
  ) u_out_stage (
    .clk      (clk),
    .rst      (rst),
    .in_valid (os_in_valid),
    .in_ready (os_in_ready),
    .in_data  (sel_data),
    .in_last  (sel_last),
    .out_valid(m_tvalid_out),
    .out_ready(m_tready_in),
    .out_data (m_tdata_out),
    .out_last (m_last_out)
  );

endmodule

// File: tb/tb_axis_rr_arb2.sv
// Directed bench for axis_rr_arb2: reset, single packet, contention, backpressure, lock, wrap, mid-packet reset.
// Inputs change and outputs are sampled 1ns after each rising edge.
// Every check is inline in its scenario task.
module tb_axis_rr_arb2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s0_tdata_in, s1_tdata_in;
  logic       s0_tvalid_in, s0_last_in, s0_tready_out;
  logic       s1_tvalid_in, s1_last_in, s1_tready_out;
  logic [7:0] m_tdata_out;
  logic       m_tvalid_out, m_last_out, m_tready_in;
  logic [1:0] grant_out;
  logic [7:0] pkt_cnt0_out, pkt_cnt1_out;

  int n_tests = 0;
  int n_fail  = 0;

  axis_rr_arb2 #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .s0_tdata_in(s0_tdata_in), .s0_tvalid_in(s0_tvalid_in), .s0_last_in(s0_last_in), .s0_tready_out(s0_tready_out),
    .s1_tdata_in(s1_tdata_in), .s1_tvalid_in(s1_tvalid_in), .s1_last_in(s1_last_in), .s1_tready_out(s1_tready_out),
    .m_tdata_out(m_tdata_out), .m_tvalid_out(m_tvalid_out), .m_last_out(m_last_out), .m_tready_in(m_tready_in),
    .grant_out(grant_out), .pkt_cnt0_out(pkt_cnt0_out), .pkt_cnt1_out(pkt_cnt1_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s0_tdata_in = 8'd0; s0_tvalid_in = 1'b0; s0_last_in = 1'b0;
    s1_tdata_in = 8'd0; s1_tvalid_in = 1'b0; s1_last_in = 1'b0;
    m_tready_in = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Reset with both ports requesting: everything must read back at reset values
  task automatic test_reset();
    idle_inputs();
    s0_tvalid_in = 1'b1; s0_tdata_in = 8'hAA;
    s1_tvalid_in = 1'b1; s1_tdata_in = 8'h55;
    rst = 1'b1;
    step();
    step();
    n_tests++;
    if ({grant_out, m_tvalid_out, m_last_out, m_tdata_out} !== {2'b00, 1'b0, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL reset_out: grant/valid/last/data=%b/%b/%b/%h expected 00/0/0/00", grant_out, m_tvalid_out, m_last_out, m_tdata_out);
    end
    n_tests++;
    if ({pkt_cnt0_out, pkt_cnt1_out, s0_tready_out, s1_tready_out} !== {8'd0, 8'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_cnt_rdy: cnt0=%0d cnt1=%0d rdy0=%b rdy1=%b expected 0 0 0 0", pkt_cnt0_out, pkt_cnt1_out, s0_tready_out, s1_tready_out);
    end
    rst = 1'b0;
    idle_inputs();
    step();
  endtask

  // s0 sends 2,3,5(last): one arbitration cycle, then consecutive beats
  task automatic test_single();
    do_reset();
    s0_tvalid_in = 1'b1; s0_tdata_in = 8'd2; s0_last_in = 1'b0;
    #1;
    n_tests++;
    if (s0_tready_out !== 1'b0) begin n_fail++; $display("FAIL single_idle_rdy: got %b expected 0", s0_tready_out); end
    step();
    n_tests++;
    if ({grant_out, s0_tready_out, m_tvalid_out} !== {2'b01, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL single_grant: grant/rdy/mvalid=%b/%b/%b expected 01/1/0", grant_out, s0_tready_out, m_tvalid_out);
    end
    step();
    n_tests++;
    if ({m_tvalid_out, m_last_out, m_tdata_out} !== {1'b1, 1'b0, 8'd2}) begin
      n_fail++; $display("FAIL single_b0: v/l/d=%b/%b/%0d expected 1/0/2", m_tvalid_out, m_last_out, m_tdata_out);
    end
    s0_tdata_in = 8'd3;
    step();
    n_tests++;
    if ({m_tvalid_out, m_last_out, m_tdata_out} !== {1'b1, 1'b0, 8'd3}) begin
      n_fail++; $display("FAIL single_b1: v/l/d=%b/%b/%0d expected 1/0/3", m_tvalid_out, m_last_out, m_tdata_out);
    end
    s0_tdata_in = 8'd5; s0_last_in = 1'b1;
    step();
    n_tests++;
    if ({m_tvalid_out, m_last_out, m_tdata_out} !== {1'b1, 1'b1, 8'd5}) begin
      n_fail++; $display("FAIL single_b2: v/l/d=%b/%b/%0d expected 1/1/5", m_tvalid_out, m_last_out, m_tdata_out);
    end
    n_tests++;
    if ({pkt_cnt0_out, pkt_cnt1_out, grant_out, s0_tready_out} !== {8'd1, 8'd0, 2'b00, 1'b0}) begin
      n_fail++; $display("FAIL single_end: cnt0=%0d cnt1=%0d grant=%b rdy0=%b expected 1 0 00 0", pkt_cnt0_out, pkt_cnt1_out, grant_out, s0_tready_out);
    end
    idle_inputs();
    step();
    n_tests++;
    if (m_tvalid_out !== 1'b0) begin n_fail++; $display("FAIL single_drain: m_tvalid=%b expected 0", m_tvalid_out); end
  endtask

  // Both ports request after reset: s0 {6,8} then s1 {9,12}
  task automatic test_contention();
    do_reset();
    s0_tvalid_in = 1'b1; s0_tdata_in = 8'd6; s0_last_in = 1'b0;
    s1_tvalid_in = 1'b1; s1_tdata_in = 8'd9; s1_last_in = 1'b0;
    step();
    n_tests++;
    if ({grant_out, s0_tready_out, s1_tready_out} !== {2'b01, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL cont_grant0: grant/rdy0/rdy1=%b/%b/%b expected 01/1/0", grant_out, s0_tready_out, s1_tready_out);
    end
    step();
    n_tests++;
    if (m_tdata_out !== 8'd6) begin n_fail++; $display("FAIL cont_b6: got %0d expected 6", m_tdata_out); end
    s0_tdata_in = 8'd8; s0_last_in = 1'b1;
    step();
    n_tests++;
    if ({m_last_out, m_tdata_out, pkt_cnt0_out, grant_out} !== {1'b1, 8'd8, 8'd1, 2'b00}) begin
      n_fail++; $display("FAIL cont_b8: last/d/cnt0/grant=%b/%0d/%0d/%b expected 1/8/1/00", m_last_out, m_tdata_out, pkt_cnt0_out, grant_out);
    end
    s0_tvalid_in = 1'b0; s0_last_in = 1'b0;
    step();
    n_tests++;
    if ({grant_out, s1_tready_out} !== {2'b10, 1'b1}) begin
      n_fail++; $display("FAIL cont_grant1: grant/rdy1=%b/%b expected 10/1", grant_out, s1_tready_out);
    end
    step();
    n_tests++;
    if (m_tdata_out !== 8'd9) begin n_fail++; $display("FAIL cont_b9: got %0d expected 9", m_tdata_out); end
    s1_tdata_in = 8'd12; s1_last_in = 1'b1;
    step();
    n_tests++;
    if ({m_last_out, m_tdata_out, pkt_cnt0_out, pkt_cnt1_out} !== {1'b1, 8'd12, 8'd1, 8'd1}) begin
      n_fail++; $display("FAIL cont_b12: last/d/cnt0/cnt1=%b/%0d/%0d/%0d expected 1/12/1/1", m_last_out, m_tdata_out, pkt_cnt0_out, pkt_cnt1_out);
    end
    idle_inputs();
    step();
  endtask

  // Downstream stalls 3 cycles after beat 10 of {10,11,12,13}
  task automatic test_backpressure();
    do_reset();
    s0_tvalid_in = 1'b1; s0_tdata_in = 8'd10; s0_last_in = 1'b0;
    step();
    step();
    s0_tdata_in = 8'd11;
    m_tready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if ({m_tvalid_out, m_tdata_out, s0_tready_out} !== {1'b1, 8'd10, 1'b0}) begin
        n_fail++; $display("FAIL bp_hold%0d: v/d/rdy0=%b/%0d/%b expected 1/10/0", i, m_tvalid_out, m_tdata_out, s0_tready_out);
      end
    end
    m_tready_in = 1'b1;
    #1;
    n_tests++;
    if (s0_tready_out !== 1'b1) begin n_fail++; $display("FAIL bp_release: rdy0=%b expected 1", s0_tready_out); end
    step();
    n_tests++;
    if (m_tdata_out !== 8'd11) begin n_fail++; $display("FAIL bp_b11: got %0d expected 11", m_tdata_out); end
    s0_tdata_in = 8'd12;
    step();
    n_tests++;
    if (m_tdata_out !== 8'd12) begin n_fail++; $display("FAIL bp_b12: got %0d expected 12", m_tdata_out); end
    s0_tdata_in = 8'd13; s0_last_in = 1'b1;
    step();
    n_tests++;
    if ({m_last_out, m_tdata_out, pkt_cnt0_out} !== {1'b1, 8'd13, 8'd1}) begin
      n_fail++; $display("FAIL bp_b13: last/d/cnt0=%b/%0d/%0d expected 1/13/1", m_last_out, m_tdata_out, pkt_cnt0_out);
    end
    idle_inputs();
    step();
  endtask

  // s1 waits while s0's packet has a tvalid gap
  task automatic test_lock();
    do_reset();
    s0_tvalid_in = 1'b1; s0_tdata_in = 8'd20; s0_last_in = 1'b0;
    step();
    s1_tvalid_in = 1'b1; s1_tdata_in = 8'd30; s1_last_in = 1'b0;
    step();
    s0_tvalid_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++;
      if ({grant_out, s1_tready_out, m_tvalid_out} !== {2'b01, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL lock_gap%0d: grant/rdy1/mvalid=%b/%b/%b expected 01/0/0", i, grant_out, s1_tready_out, m_tvalid_out);
      end
    end
    s0_tvalid_in = 1'b1; s0_tdata_in = 8'd21; s0_last_in = 1'b1;
    step();
    n_tests++;
    if ({m_last_out, m_tdata_out, pkt_cnt0_out, s1_tready_out} !== {1'b1, 8'd21, 8'd1, 1'b0}) begin
      n_fail++; $display("FAIL lock_end: last/d/cnt0/rdy1=%b/%0d/%0d/%b expected 1/21/1/0", m_last_out, m_tdata_out, pkt_cnt0_out, s1_tready_out);
    end
    s0_tvalid_in = 1'b0; s0_last_in = 1'b0;
    step();
    n_tests++;
    if ({grant_out, s1_tready_out} !== {2'b10, 1'b1}) begin
      n_fail++; $display("FAIL lock_switch: grant/rdy1=%b/%b expected 10/1", grant_out, s1_tready_out);
    end
    s1_last_in = 1'b1;
    step();
    n_tests++;
    if ({m_tdata_out, pkt_cnt1_out} !== {8'd30, 8'd1}) begin
      n_fail++; $display("FAIL lock_s1: d/cnt1=%0d/%0d expected 30/1", m_tdata_out, pkt_cnt1_out);
    end
    idle_inputs();
    step();
  endtask

  // 256 single-beat packets on s0 bring the 8-bit counter back to 0
  task automatic test_wrap();
    do_reset();
    s0_tvalid_in = 1'b1; s0_tdata_in = 8'h77; s0_last_in = 1'b1;
    for (int i = 0; i < 2 * 255; i++) step();
    n_tests++;
    if (pkt_cnt0_out !== 8'd255) begin n_fail++; $display("FAIL wrap_255: cnt0=%0d expected 255", pkt_cnt0_out); end
    step();
    step();
    n_tests++;
    if ({pkt_cnt0_out, pkt_cnt1_out} !== {8'd0, 8'd0}) begin
      n_fail++; $display("FAIL wrap_0: cnt0=%0d cnt1=%0d expected 0 0", pkt_cnt0_out, pkt_cnt1_out);
    end
    idle_inputs();
    step();
  endtask

  // Reset after beat 2 of 4, with the pointer favouring s1 beforehand
  task automatic test_reset_mid();
    do_reset();
    s0_tvalid_in = 1'b1; s0_tdata_in = 8'd1; s0_last_in = 1'b1;
    step();
    step();
    s0_tdata_in = 8'd40; s0_last_in = 1'b0;
    step();
    step();
    s0_tdata_in = 8'd41;
    step();
    n_tests++;
    if ({m_tdata_out, pkt_cnt0_out} !== {8'd41, 8'd1}) begin
      n_fail++; $display("FAIL rmid_pre: d/cnt0=%0d/%0d expected 41/1", m_tdata_out, pkt_cnt0_out);
    end
    s0_tdata_in = 8'd42;
    rst = 1'b1;
    step();
    n_tests++;
    if ({grant_out, m_tvalid_out, m_last_out, m_tdata_out, pkt_cnt0_out, pkt_cnt1_out, s0_tready_out, s1_tready_out} !==
        {2'b00, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL rmid_reset: grant=%b v=%b l=%b d=%0d cnt0=%0d cnt1=%0d rdy=%b%b expected all 0",
                         grant_out, m_tvalid_out, m_last_out, m_tdata_out, pkt_cnt0_out, pkt_cnt1_out, s0_tready_out, s1_tready_out);
    end
    rst = 1'b0;
    s1_tvalid_in = 1'b1; s1_tdata_in = 8'd50;
    step();
    n_tests++;
    if (grant_out !== 2'b01) begin n_fail++; $display("FAIL rmid_ptr: grant=%b expected 01", grant_out); end
    step();
    n_tests++;
    if (m_tdata_out !== 8'd42) begin n_fail++; $display("FAIL rmid_resume: d=%0d expected 42", m_tdata_out); end
    idle_inputs();
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_lock();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
